// File: rtl/poolb_ctrl_u6_s2k2.sv
// ---------------------------------------------------------------------------
// poolb_ctrl_u6_s2k2
// Sequencer for the 6-unit, 2x2 stride-2 max-pool stage. One pass pools one
// group of feature maps. Port A reads the even row of each row pair and
// port B reads the odd row, one column per cycle. The block also drives the
// fifo/pool strobes of the datapath and generates the write addresses for
// the next layer's buffers. ifm_sel_next names the map group being written.
// ---------------------------------------------------------------------------
module poolb_ctrl_u6_s2k2 #(
    parameter int IFM_SIZE              = 10,
    parameter int IFM_DEPTH             = 16,
    parameter int KERNAL_SIZE           = 2,
    parameter int NUMBER_OF_UNITS       = 6,
    parameter int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / 2 + 1,
    parameter int GROUPS                = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int SEL_SIZE              = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_from_previous,
    input  logic                             conv_ready,
    input  logic                             end_from_next,
    output logic                             end_to_previous,
    output logic                             ifm_enable_read_A_current,
    output logic                             ifm_enable_read_B_current,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_A_current,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_B_current,
    output logic                             fifo_enable,
    output logic                             pool_enable,
    output logic                             ifm_enable_write_next,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
    output logic                             start_to_next,
    output logic [SEL_SIZE-1:0]              ifm_sel_next
);

    // Output map size and the counter geometry of one pass.
    localparam int OS       = IFM_SIZE_NEXT;
    localparam int ROW_W    = (OS > 1) ? $clog2(OS) : 1;
    localparam int COL_W    = $clog2(2 * OS);
    localparam int LAST_ROW = OS - 1;
    localparam int LAST_COL = 2 * OS - 1;

    // IDLE waits for work. RUN issues one read per cycle. The two FLUSH states
    // drain the pool and write stages behind the last read.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_RUN         = 2'd1,
        ST_FLUSH_POOL  = 2'd2,
        ST_FLUSH_WRITE = 2'd3
    } state_t;

    state_t                           state_r;
    logic [ROW_W-1:0]                 row_r;
    logic [COL_W-1:0]                 col_r;
    logic [ROW_W-1:0]                 next_row_s;
    logic [COL_W-1:0]                 next_col_s;
    logic [ADDRESS_SIZE_IFM-1:0]      next_addr_a_s;
    logic [ADDRESS_SIZE_IFM-1:0]      next_addr_b_s;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] pool_addr_s;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] pool_addr_r;
    logic                             last_read_s;
    logic                             launch_s;
    logic                             sel_last_s;

    logic                             pending_start_r;
    logic                             buf_free_r;
    logic                             rd_en_r;
    logic [ADDRESS_SIZE_IFM-1:0]      addr_a_r;
    logic [ADDRESS_SIZE_IFM-1:0]      addr_b_r;
    logic                             fifo_en_r;
    logic                             pool_en_r;
    logic                             wr_en_r;
    logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr_r;
    logic                             end_prev_r;
    logic                             start_next_r;
    logic [SEL_SIZE-1:0]              sel_r;

    // Next read position and its addresses, launch condition, group wrap.
    always_comb begin
        last_read_s = (row_r == ROW_W'(LAST_ROW)) && (col_r == COL_W'(LAST_COL));
        next_row_s  = '0;
        next_col_s  = '0;
        if ((state_r == ST_RUN) && !last_read_s) begin
            if (col_r == COL_W'(LAST_COL)) begin
                next_row_s = row_r + ROW_W'(1);
                next_col_s = '0;
            end else begin
                next_row_s = row_r;
                next_col_s = col_r + COL_W'(1);
            end
        end else begin
            // Every pass starts at row 0, column 0.
            next_row_s = '0;
            next_col_s = '0;
        end
        // Row pair r covers IFM rows 2r (port A) and 2r+1 (port B).
        next_addr_a_s = ADDRESS_SIZE_IFM'(32'(next_row_s) * 32'(2 * IFM_SIZE) + 32'(next_col_s));
        next_addr_b_s = next_addr_a_s + ADDRESS_SIZE_IFM'(IFM_SIZE);
        // Each odd column closes a 2x2 window. Its output goes to r*OS + c/2.
        pool_addr_s   = ADDRESS_SIZE_NEXT_IFM'(32'(row_r) * 32'(OS) + 32'(col_r >> 1'b1));
        sel_last_s    = (sel_r == SEL_SIZE'(GROUPS - 1));
        // The buffers of the next layer are only needed free at the first group.
        launch_s      = (state_r == ST_IDLE) && pending_start_r && conv_ready &&
                        ((sel_r != SEL_SIZE'(0)) || buf_free_r);
    end

    // Remember pending start and buffer-free events. A new event wins over
    // the clear that happens when a pass launches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_start_r <= 1'b0;
            buf_free_r      <= 1'b1;
        end else begin
            if (start_from_previous) begin
                pending_start_r <= 1'b1;
            end else if (launch_s) begin
                pending_start_r <= 1'b0;
            end else begin
                pending_start_r <= pending_start_r;
            end
            if (end_from_next) begin
                buf_free_r <= 1'b1;
            end else if (launch_s && (sel_r == SEL_SIZE'(0))) begin
                buf_free_r <= 1'b0;
            end else begin
                buf_free_r <= buf_free_r;
            end
        end
    end

    // Pass sequencer: read counters, read strobes and addresses, handshake pulses, group select.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            row_r        <= '0;
            col_r        <= '0;
            rd_en_r      <= 1'b0;
            addr_a_r     <= '0;
            addr_b_r     <= '0;
            end_prev_r   <= 1'b0;
            start_next_r <= 1'b0;
            sel_r        <= '0;
        end else begin
            end_prev_r   <= 1'b0;
            start_next_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_r  <= ST_RUN;
                        rd_en_r  <= 1'b1;
                        row_r    <= next_row_s;
                        col_r    <= next_col_s;
                        addr_a_r <= next_addr_a_s;
                        addr_b_r <= next_addr_b_s;
                    end else begin
                        state_r  <= ST_IDLE;
                        rd_en_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_read_s) begin
                        state_r  <= ST_FLUSH_POOL;
                        rd_en_r  <= 1'b0;
                        row_r    <= '0;
                        col_r    <= '0;
                        addr_a_r <= '0;
                        addr_b_r <= '0;
                    end else begin
                        state_r  <= ST_RUN;
                        rd_en_r  <= 1'b1;
                        row_r    <= next_row_s;
                        col_r    <= next_col_s;
                        addr_a_r <= next_addr_a_s;
                        addr_b_r <= next_addr_b_s;
                    end
                end
                ST_FLUSH_POOL: begin
                    // The release pulse lines up with the last write of the pass.
                    state_r    <= ST_FLUSH_WRITE;
                    end_prev_r <= 1'b1;
                end
                ST_FLUSH_WRITE: begin
                    // The select changes only after the last write of the group.
                    state_r <= ST_IDLE;
                    if (sel_last_s) begin
                        sel_r        <= '0;
                        start_next_r <= 1'b1;
                    end else begin
                        sel_r        <= sel_r + SEL_SIZE'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

    // Datapath strobes delayed to match the 1-cycle read latency and the pool register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_en_r   <= 1'b0;
            pool_en_r   <= 1'b0;
            pool_addr_r <= '0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
        end else begin
            fifo_en_r <= rd_en_r && !col_r[0];
            pool_en_r <= rd_en_r && col_r[0];
            if (rd_en_r && col_r[0]) begin
                pool_addr_r <= pool_addr_s;
            end else begin
                pool_addr_r <= pool_addr_r;
            end
            wr_en_r <= pool_en_r;
            if (pool_en_r) begin
                wr_addr_r <= pool_addr_r;
            end else begin
                wr_addr_r <= wr_addr_r;
            end
        end
    end

    assign end_to_previous            = end_prev_r;
    assign ifm_enable_read_A_current  = rd_en_r;
    assign ifm_enable_read_B_current  = rd_en_r;
    assign ifm_address_read_A_current = addr_a_r;
    assign ifm_address_read_B_current = addr_b_r;
    assign fifo_enable                = fifo_en_r;
    assign pool_enable                = pool_en_r;
    assign ifm_enable_write_next      = wr_en_r;
    assign ifm_address_write_next     = wr_addr_r;
    assign start_to_next              = start_next_r;
    assign ifm_sel_next               = sel_r;

endmodule

// File: tb/tb_poolb_ctrl_u6_s2k2.sv
// ---------------------------------------------------------------------------
// Bench for poolb_ctrl_u6_s2k2. A pass is modelled as a timeline that hangs
// off its first read cycle. The bench derives every expected strobe and
// address from the pass geometry. Directed scenarios come first, then a
// randomized run with rare resets.
// ---------------------------------------------------------------------------
module tb_poolb_ctrl_u6_s2k2;

    localparam int IFM    = 10;
    localparam int OS     = 5;
    localparam int GROUPS = 3;
    localparam int COLS   = 2 * OS;
    localparam int NREAD  = COLS * OS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_from_previous = 1'b0;
    logic       conv_ready = 1'b0;
    logic       end_from_next = 1'b0;
    logic       end_to_previous;
    logic       rd_a, rd_b;
    logic [6:0] addr_a, addr_b;
    logic       fifo_enable, pool_enable;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic       start_to_next;
    logic [1:0] sel;

    poolb_ctrl_u6_s2k2 dut (
        .clk                        (clk),
        .reset                      (reset),
        .start_from_previous        (start_from_previous),
        .conv_ready                 (conv_ready),
        .end_from_next              (end_from_next),
        .end_to_previous            (end_to_previous),
        .ifm_enable_read_A_current  (rd_a),
        .ifm_enable_read_B_current  (rd_b),
        .ifm_address_read_A_current (addr_a),
        .ifm_address_read_B_current (addr_b),
        .fifo_enable                (fifo_enable),
        .pool_enable                (pool_enable),
        .ifm_enable_write_next      (wr_en),
        .ifm_address_write_next     (wr_addr),
        .start_to_next              (start_to_next),
        .ifm_sel_next               (sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;     // cycle index, advanced once per clock
    int pass_s = -1;   // cycle of the first read of the current pass, -1 = none
    bit m_pend = 1'b0;
    bit m_free = 1'b1;
    int m_sel  = 0;
    bit hit12  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    // Compare all outputs of cycle n against the pass timeline.
    task automatic compare_cycle();
        int k, k1, k2, exp_wa;
        bit e_rd, e_fifo, e_pool, e_wr;
        k  = (pass_s >= 0) ? (n - pass_s) : -1000;
        k1 = k - 1;
        k2 = k - 2;
        e_rd   = (k >= 0) && (k < NREAD);
        e_fifo = (k1 >= 0) && (k1 < NREAD) && (((k1 % COLS) % 2) == 0);
        e_pool = (k1 >= 0) && (k1 < NREAD) && (((k1 % COLS) % 2) == 1);
        e_wr   = (k2 >= 0) && (k2 < NREAD) && (((k2 % COLS) % 2) == 1);
        check_val("rd_a", rd_a, e_rd);
        check_val("rd_b", rd_b, e_rd);
        if (e_rd) begin
            check_val("addr_a", addr_a, (k / COLS) * 2 * IFM + (k % COLS));
            check_val("addr_b", addr_b, ((k / COLS) * 2 + 1) * IFM + (k % COLS));
        end
        check_val("fifo_en", fifo_enable, e_fifo);
        check_val("pool_en", pool_enable, e_pool);
        check_val("wr_en", wr_en, e_wr);
        if (e_wr) begin
            exp_wa = (k2 / COLS) * OS + (k2 % COLS) / 2;
            check_val("wr_addr", wr_addr, exp_wa);
            if (exp_wa == 11) hit12 = 1'b1;
        end
        check_val("end_to_prev", end_to_previous, k == NREAD + 1);
        check_val("start_to_next", start_to_next, (k == NREAD + 2) && (m_sel == 0));
        check_val("sel", sel, m_sel);
    endtask

    // Advance the reference by one cycle using the inputs applied in cycle n.
    task automatic model_update();
        bit idle, launch;
        idle   = (pass_s < 0) || (n >= pass_s + NREAD + 2);
        launch = idle && m_pend && conv_ready && ((m_sel != 0) || m_free);
        if (end_from_next) m_free = 1'b1;
        else if (launch && (m_sel == 0)) m_free = 1'b0;
        if (start_from_previous) m_pend = 1'b1;
        else if (launch) m_pend = 1'b0;
        if ((pass_s >= 0) && (n == pass_s + NREAD + 1)) m_sel = (m_sel + 1) % GROUPS;
        if (launch) pass_s = n + 1;
    endtask

    task automatic tick(input bit s, input bit cr, input bit ef);
        @(posedge clk);
        #1;
        start_from_previous = s;
        conv_ready          = cr;
        end_from_next       = ef;
        n++;
        @(negedge clk);
        compare_cycle();
        model_update();
    endtask

    // Assert reset asynchronously and expect every output to clear at once.
    task automatic apply_reset();
        reset               = 1'b0;
        start_from_previous = 1'b0;
        end_from_next       = 1'b0;
        #1;
        check_val("rst_rd_a", rd_a, 0);
        check_val("rst_rd_b", rd_b, 0);
        check_val("rst_addr_a", addr_a, 0);
        check_val("rst_addr_b", addr_b, 0);
        check_val("rst_fifo", fifo_enable, 0);
        check_val("rst_pool", pool_enable, 0);
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_etp", end_to_previous, 0);
        check_val("rst_stn", start_to_next, 0);
        check_val("rst_sel", sel, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        pass_s = -1;
        m_pend = 1'b0;
        m_free = 1'b1;
        m_sel  = 0;
    endtask

    initial begin
        #2;
        apply_reset();

        // One pass from a single start pulse.
        tick(1'b1, 1'b1, 1'b0);
        repeat (60) tick(1'b0, 1'b1, 1'b0);
        // Two more passes. The select wraps and start_to_next pulses.
        repeat (2) begin
            tick(1'b1, 1'b1, 1'b0);
            repeat (60) tick(1'b0, 1'b1, 1'b0);
        end
        // Group 0 is blocked until the next layer frees its buffers.
        tick(1'b1, 1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        repeat (60) tick(1'b0, 1'b1, 1'b0);
        // Start is held pending while conv_ready is low.
        tick(1'b1, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b0);
        repeat (60) tick(1'b0, 1'b1, 1'b0);
        // A start pulse during RUN queues a back-to-back pass.
        tick(1'b1, 1'b1, 1'b0);
        repeat (10) tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        repeat (120) tick(1'b0, 1'b1, 1'b0);
        // Reset at the twelfth write. The next pass restarts cleanly.
        hit12 = 1'b0;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; (i < 100) && !hit12; i++) tick(1'b0, 1'b1, 1'b0);
        check_val("reach_write12", hit12, 1);
        apply_reset();
        tick(1'b1, 1'b1, 1'b0);
        repeat (60) tick(1'b0, 1'b1, 1'b0);

        // Randomized traffic with rare resets.
        for (int i = 0; i < 2500; i++) begin
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0);
            if ($urandom_range(0, 999) == 0) apply_reset();
        end
        repeat (60) tick(1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
